// File: rtl/score_keeper.sv
// score_keeper
//   Game-side score engine feeding the seven-segment display. It tracks the
//   game state (IDLE / PLAYING / OVER), turns hit/miss/collision levels from
//   the play logic into single-cycle events, accumulates combo-weighted
//   points with 16-bit saturation and keeps the best score since reset.
//   A registered mux picks the live score or the high score for the display.
//
// Parameters
//   BASE_POINTS    points per hit at combo 0 (1..65535)
//   MAX_COMBO      combo ceiling (0..7)
//
// Ports
//   clk            system clock
//   reset          synchronous, active-high reset
//   start_game     starts a game from IDLE or OVER
//   hit            level from play logic, rising edge = one hit
//   miss           level from play logic, rising edge = one miss
//   collision      level from play logic, rising edge ends the game
//   show_high      1 selects high_score for the display, 0 selects score
//   score          current game score
//   high_score     best score since reset
//   combo          current combo level, 0..MAX_COMBO
//   state          00 IDLE, 01 PLAYING, 10 OVER
//   new_high       set while in OVER when the last game beat the high score
//   display_value  registered display mux output
module score_keeper #(
  parameter int BASE_POINTS = 10,
  parameter int MAX_COMBO   = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_game,
  input  logic        hit,
  input  logic        miss,
  input  logic        collision,
  input  logic        show_high,
  output logic [15:0] score,
  output logic [15:0] high_score,
  output logic [2:0]  combo,
  output logic [1:0]  state,
  output logic        new_high,
  output logic [15:0] display_value
);

  // 2'b11 is listed so the illegal encoding can be named and recovered from.
  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_PLAYING = 2'b01,
    S_OVER    = 2'b10,
    S_ILLEGAL = 2'b11
  } state_t;

  localparam logic [19:0] BASE20    = 20'(BASE_POINTS);
  localparam logic [2:0]  MAX_COMBO3 = 3'(MAX_COMBO);

  state_t      state_q;
  state_t      state_d;

  logic        hit_q;
  logic        miss_q;
  logic        coll_q;
  logic        hit_ev;
  logic        miss_ev;
  logic        coll_ev;

  logic [15:0] score_q;
  logic [15:0] score_d;
  logic [15:0] high_q;
  logic [15:0] high_d;
  logic [2:0]  combo_q;
  logic [2:0]  combo_d;
  logic        new_high_q;
  logic        new_high_d;
  logic [15:0] display_q;

  logic [19:0] combo_mult;
  logic [19:0] points;
  logic [19:0] sum20;
  logic [15:0] score_sat;
  logic [2:0]  combo_inc;

  // An event fires only in the first cycle its level is seen high, so a
  // held input counts once.
  assign hit_ev  = hit       & ~hit_q;
  assign miss_ev = miss      & ~miss_q;
  assign coll_ev = collision & ~coll_q;

  // Edge-detect history is sampled every cycle in every state, so a level
  // held across a state change does not produce a late event.
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_q  <= 1'b0;
      miss_q <= 1'b0;
      coll_q <= 1'b0;
    end else begin
      hit_q  <= hit;
      miss_q <= miss;
      coll_q <= collision;
    end
  end

  // Hit value and saturating add. The sum is formed in 20 bits: the largest
  // product (65535 * 8) still fits, so the clamp only needs the top nibble.
  always_comb begin
    combo_mult = 20'(combo_q) + 20'd1;
    points     = BASE20 * combo_mult;
    sum20      = {4'b0000, score_q} + points;
    score_sat  = (sum20[19:16] != 4'b0000) ? 16'hFFFF : sum20[15:0];
    combo_inc  = (combo_q >= MAX_COMBO3) ? MAX_COMBO3 : combo_q + 3'd1;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Only a collision leaves PLAYING; start_game is
  // ignored while a game is running.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start_game) state_d = S_PLAYING;
      S_PLAYING: if (coll_ev)    state_d = S_OVER;
      S_OVER:    if (start_game) state_d = S_PLAYING;
      default:   state_d = S_IDLE;
    endcase
  end

  // Datapath next values per state. Within PLAYING the event priority is
  // collision > miss > hit, so a lower-priority event in the same cycle is
  // dropped. The high-score compare happens on the PLAYING->OVER edge and
  // is strict: tying the high score is not a new high.
  always_comb begin
    score_d    = score_q;
    combo_d    = combo_q;
    high_d     = high_q;
    new_high_d = new_high_q;
    case (state_q)
      S_IDLE: begin
        score_d = 16'd0;
        combo_d = 3'd0;
      end
      S_PLAYING: begin
        if (coll_ev) begin
          if (score_q > high_q) begin
            high_d     = score_q;
            new_high_d = 1'b1;
          end else begin
            new_high_d = 1'b0;
          end
        end else if (miss_ev) begin
          combo_d = 3'd0;
        end else if (hit_ev) begin
          score_d = score_sat;
          combo_d = combo_inc;
        end
      end
      S_OVER: begin
        if (start_game) begin
          score_d    = 16'd0;
          combo_d    = 3'd0;
          new_high_d = 1'b0;
        end
      end
      default: begin
        score_d    = 16'd0;
        combo_d    = 3'd0;
        new_high_d = 1'b0;
      end
    endcase
  end

  // Score/combo/high-score registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      score_q    <= 16'd0;
      combo_q    <= 3'd0;
      high_q     <= 16'd0;
      new_high_q <= 1'b0;
    end else begin
      score_q    <= score_d;
      combo_q    <= combo_d;
      high_q     <= high_d;
      new_high_q <= new_high_d;
    end
  end

  // Display mux, registered so it lags the selected source by one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      display_q <= 16'd0;
    end else begin
      display_q <= show_high ? high_q : score_q;
    end
  end

  assign score         = score_q;
  assign high_score    = high_q;
  assign combo         = combo_q;
  assign state         = state_q;
  assign new_high      = new_high_q;
  assign display_value = display_q;

endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper
//   Directed bench for score_keeper. Two instances share the same stimulus:
//   one with default parameters and one with BASE_POINTS=20000, MAX_COMBO=0
//   to exercise saturation. Inputs change 1 time unit after a rising edge,
//   outputs are checked at that same point.
module tb_score_keeper;

  logic        clk;
  logic        reset;
  logic        start_game;
  logic        hit;
  logic        miss;
  logic        collision;
  logic        show_high;

  logic [15:0] score;
  logic [15:0] high_score;
  logic [2:0]  combo;
  logic [1:0]  state;
  logic        new_high;
  logic [15:0] display_value;

  logic [15:0] s_score;
  logic [15:0] s_high_score;
  logic [2:0]  s_combo;
  logic [1:0]  s_state;
  logic        s_new_high;
  logic [15:0] s_display_value;

  int testsRun;
  int testsFailed;

  score_keeper dut (
    .clk           (clk),
    .reset         (reset),
    .start_game    (start_game),
    .hit           (hit),
    .miss          (miss),
    .collision     (collision),
    .show_high     (show_high),
    .score         (score),
    .high_score    (high_score),
    .combo         (combo),
    .state         (state),
    .new_high      (new_high),
    .display_value (display_value)
  );

  score_keeper #(.BASE_POINTS(20000), .MAX_COMBO(0)) dut_sat (
    .clk           (clk),
    .reset         (reset),
    .start_game    (start_game),
    .hit           (hit),
    .miss          (miss),
    .collision     (collision),
    .show_high     (show_high),
    .score         (s_score),
    .high_score    (s_high_score),
    .combo         (s_combo),
    .state         (s_state),
    .new_high      (s_new_high),
    .display_value (s_display_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, then step past the next rising edge.
  task automatic applyStimulus(input logic s, input logic h, input logic m, input logic c);
    start_game = s;
    hit        = h;
    miss       = m;
    collision  = c;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Single-cycle pulse on the chosen event inputs followed by a quiet cycle.
  task automatic pulse(input logic h, input logic m, input logic c);
    applyStimulus(1'b0, h, m, c);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic doReset();
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
  endtask

  int scoreExp[5] = '{10, 30, 60, 100, 140};
  int comboExp[5] = '{1, 2, 3, 3, 3};
  int satExp[5]   = '{20000, 40000, 60000, 65535, 65535};

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    reset       = 1'b1;
    start_game  = 1'b0;
    hit         = 1'b0;
    miss        = 1'b0;
    collision   = 1'b0;
    show_high   = 1'b0;

    // Reset state, including hits that arrive while reset is held.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("rst_score", 32'(score), 0);
    checkOutput("rst_high", 32'(high_score), 0);
    checkOutput("rst_combo", 32'(combo), 0);
    checkOutput("rst_state", 32'(state), 0);
    checkOutput("rst_new_high", 32'(new_high), 0);
    checkOutput("rst_display", 32'(display_value), 0);
    reset = 1'b0;

    // Hits in IDLE are ignored.
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    checkOutput("idle_score", 32'(score), 0);
    checkOutput("idle_state", 32'(state), 0);

    // Start, then five hit pulses with combo weighting on both instances.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("start_state", 32'(state), 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput($sformatf("hit%0d_score", i), 32'(score), 32'(scoreExp[i]));
      checkOutput($sformatf("hit%0d_combo", i), 32'(combo), 32'(comboExp[i]));
      checkOutput($sformatf("sat%0d_score", i), 32'(s_score), 32'(satExp[i]));
      checkOutput($sformatf("sat%0d_combo", i), 32'(s_combo), 0);
      if (i == 0) checkOutput("display_lag", 32'(display_value), 0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      if (i == 0) checkOutput("display_follow", 32'(display_value), 10);
    end

    // start_game while playing is ignored.
    pulse(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("start_in_play_score", 32'(score), 140);
    checkOutput("start_in_play_state", 32'(state), 1);

    // End game 1 and restart for the held-hit check.
    pulse(1'b0, 1'b0, 1'b1);
    checkOutput("g1_state", 32'(state), 2);
    checkOutput("g1_high", 32'(high_score), 140);
    checkOutput("g1_new_high", 32'(new_high), 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("restart_score", 32'(score), 0);
    checkOutput("restart_combo", 32'(combo), 0);

    // A hit held for six cycles counts exactly once.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput($sformatf("held%0d_score", i), 32'(score), 10);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    // Fresh game: two hits, miss, hit, then a simultaneous hit+miss.
    pulse(1'b0, 1'b0, 1'b1);
    checkOutput("g2_new_high", 32'(new_high), 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    checkOutput("two_hits_score", 32'(score), 30);
    pulse(1'b0, 1'b1, 1'b0);
    checkOutput("miss_combo", 32'(combo), 0);
    checkOutput("miss_score", 32'(score), 30);
    pulse(1'b1, 1'b0, 1'b0);
    checkOutput("after_miss_score", 32'(score), 40);
    checkOutput("after_miss_combo", 32'(combo), 1);
    pulse(1'b1, 1'b1, 1'b0);
    checkOutput("hit_miss_score", 32'(score), 40);
    checkOutput("hit_miss_combo", 32'(combo), 0);

    // High-score bookkeeping from a clean reset.
    doReset();
    checkOutput("rst2_high", 32'(high_score), 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    checkOutput("pre_coll_score", 32'(score), 60);
    pulse(1'b1, 1'b0, 1'b1);
    checkOutput("coll_hit_score", 32'(score), 60);
    checkOutput("coll_hit_state", 32'(state), 2);
    checkOutput("coll_hit_high", 32'(high_score), 60);
    checkOutput("coll_hit_new_high", 32'(new_high), 1);
    pulse(1'b1, 1'b0, 1'b0);
    checkOutput("over_hit_score", 32'(score), 60);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("restart2_state", 32'(state), 1);
    checkOutput("restart2_score", 32'(score), 0);
    checkOutput("restart2_new_high", 32'(new_high), 0);
    checkOutput("restart2_high", 32'(high_score), 60);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b1);
    checkOutput("g2b_score", 32'(score), 30);
    checkOutput("g2b_high", 32'(high_score), 60);
    checkOutput("g2b_new_high", 32'(new_high), 0);
    show_high = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("show_high_display", 32'(display_value), 60);
    show_high = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("show_score_display", 32'(display_value), 30);

    // Tying the high score is not a new high.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b1);
    checkOutput("tie_score", 32'(score), 60);
    checkOutput("tie_high", 32'(high_score), 60);
    checkOutput("tie_new_high", 32'(new_high), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
